// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 VGA timing generator with a WIN_W x WIN_H frame-buffer window
//   anchored at the top-left corner. The window flag (active_o) and the
//   undelayed vsync (vsync_o) feed an external address generator; the RAM
//   read data (pixel_i) returns 1+RD_LAT clocks later and is merged with the
//   equally delayed sync/blank flags into the registered video outputs.
//
// Ports
//   CLK25        in   pixel clock, the only clock
//   rst_i        in   synchronous active-high reset
//   pixel_i      in   [11:0] RGB444 frame-buffer read data
//   active_o     out  window pixel request (address-generator enable)
//   vsync_o      out  undelayed active-low vsync (address-generator frame reset)
//   vga_hsync    out  active-low hsync aligned with video
//   vga_vsync    out  active-low vsync aligned with video
//   vga_blank_n  out  high inside the visible area, aligned with video
//   vga_r/g/b    out  [3:0] pixel colour
module vga_timing_gen #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          WIN_W      = 320,
  parameter int          WIN_H      = 240,
  parameter int          RD_LAT     = 1,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic        CLK25,
  input  logic        rst_i,
  input  logic [11:0] pixel_i,
  output logic        active_o,
  output logic        vsync_o,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // Flag pipeline depth: address register in the generator plus RAM latency.
  localparam int D       = 1 + RD_LAT;

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS        = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_WIN        = HW'(WIN_W);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS        = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_WIN        = VW'(WIN_H);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hs_dec;
  logic          vis_dec;
  logic [D-1:0]  hs_pipe;
  logic [D-1:0]  vs_pipe;
  logic [D-1:0]  vis_pipe;
  logic [D-1:0]  win_pipe;
  logic [11:0]   rgb_next;

  // Horizontal/vertical position counters; v_cnt advances on the h_cnt wrap.
  always_ff @(posedge CLK25) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Registered decode of the counters (one clock behind them).
  // active_o doubles as the window flag entering the video pipeline.
  always_ff @(posedge CLK25) begin
    if (rst_i) begin
      active_o <= 1'b0;
      vsync_o  <= 1'b1;
      hs_dec   <= 1'b1;
      vis_dec  <= 1'b0;
    end else begin
      active_o <= (h_cnt < H_WIN) && (v_cnt < V_WIN);
      vsync_o  <= !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
      hs_dec   <= !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
      vis_dec  <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
    end
  end

  // Delay the flags by D clocks so they line up with pixel_i.
  always_ff @(posedge CLK25) begin
    if (rst_i) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      vis_pipe <= '0;
      win_pipe <= '0;
    end else begin
      hs_pipe  <= {hs_pipe[D-2:0], hs_dec};
      vs_pipe  <= {vs_pipe[D-2:0], vsync_o};
      vis_pipe <= {vis_pipe[D-2:0], vis_dec};
      win_pipe <= {win_pipe[D-2:0], active_o};
    end
  end

  // Colour select from the delayed flags: frame buffer, border or black.
  always_comb begin
    rgb_next = 12'h000;
    if (vis_pipe[D-1] && win_pipe[D-1]) begin
      rgb_next = pixel_i;
    end else if (vis_pipe[D-1]) begin
      rgb_next = BORDER_RGB;
    end else begin
      rgb_next = 12'h000;
    end
  end

  // Output register: syncs and blank take the same extra stage as the colour.
  always_ff @(posedge CLK25) begin
    if (rst_i) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
    end else begin
      vga_hsync   <= hs_pipe[D-1];
      vga_vsync   <= vs_pipe[D-1];
      vga_blank_n <= vis_pipe[D-1];
      vga_r       <= rgb_next[11:8];
      vga_g       <= rgb_next[7:4];
      vga_b       <= rgb_next[3:0];
    end
  end

endmodule
